// File: rtl/multicycle_shifter.sv
// Multicycle 32-bit shifter: SLL / SRA computed over five clock edges by a
// 16/8/4/2/1 stage sequence applied to a single working register, with a
// valid/ready handshake on both sides and an optional zero-amount bypass.
module multicycle_shifter #(
  parameter int FAST_ZERO = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_operand,
  input  logic [4:0]  in_shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] work;
  logic              op;
  logic [4:0]        amt;
  logic [2:0]        step;

  // One stage of the barrel sequence: step 0..4 selects weight 16..1 and the
  // matching amount bit. SRA fills from bit 31 of the current working value.
  function automatic logic [DATA_W-1:0] stage_shift(
    input logic [DATA_W-1:0] v,
    input logic              sra,
    input logic [2:0]        idx,
    input logic [4:0]        a
  );
    logic signed [DATA_W-1:0] sv;
    logic [4:0]               w;
    logic                     en;
    sv = signed'(v);
    w  = 5'd16 >> idx;
    case (idx)
      3'd0:    en = a[4];
      3'd1:    en = a[3];
      3'd2:    en = a[2];
      3'd3:    en = a[1];
      3'd4:    en = a[0];
      default: en = 1'b0;
    endcase
    if (!en) begin
      return v;
    end
    if (sra) begin
      return DATA_W'(sv >>> w);
    end
    return v << w;
  endfunction

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    out_result = work;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          // A zero amount needs no stages, so it may skip straight to DONE.
          if ((FAST_ZERO != 0) && (in_shamt == 5'd0)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (step == 3'd4) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request capture on acceptance, then one shift stage per edge in SHIFT.
  // Operands are only sampled in IDLE, so later input changes are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      work <= '0;
      op   <= 1'b0;
      amt  <= 5'd0;
      step <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_operand;
            op   <= in_op;
            amt  <= in_shamt;
            step <= 3'd0;
          end
        end
        SHIFT: begin
          work <= stage_shift(work, op, step, amt);
          step <= step + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_shifter.sv
// Self-checking bench for multicycle_shifter: a transaction-level reference
// (result from plain shift operators, timing as "edges until valid") is
// compared against the DUT every cycle, plus directed literal cases.
module tb_multicycle_shifter;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_operand;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  // Second instance without the zero-amount bypass.
  logic        z_in_valid;
  logic        z_in_ready;
  logic        z_in_op;
  logic [31:0] z_in_operand;
  logic [4:0]  z_in_shamt;
  logic        z_out_valid;
  logic        z_out_ready;
  logic [31:0] z_out_result;
  logic        z_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  multicycle_shifter #(.FAST_ZERO(1)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_operand(in_operand), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy)
  );

  multicycle_shifter #(.FAST_ZERO(0)) dut_slow (
    .clock(clock), .reset(reset),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_op(z_in_op),
    .in_operand(z_in_operand), .in_shamt(z_in_shamt),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_result(z_out_result),
    .busy(z_busy)
  );

  function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] v,
                                            input logic [4:0] s);
    logic signed [31:0] sv;
    sv = v;
    if (op) return sv >>> s;
    return v << s;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding request, result known at acceptance,
  // valid after 5 further edges (0 for a bypassed zero amount).
  logic        m_active;
  int          m_wait;
  logic [31:0] m_result;
  int          n_accept;
  int          n_deliver;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_wait   = 0;
      m_result = 32'h0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active = 1'b1;
        m_result = ref_shift(in_op, in_operand, in_shamt);
        m_wait   = (in_shamt == 5'd0) ? 0 : 5;
        n_accept++;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (out_ready) begin
      m_active = 1'b0;
    end
  end

  // Results actually handed over by the DUT (pre-edge values at the edge).
  always @(posedge clock) begin
    if (reset && out_valid && out_ready) n_deliver++;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      check1("in_ready", in_ready, !m_active);
      check1("busy", busy, m_active);
      check1("out_valid", out_valid, m_active && (m_wait == 0));
      if (m_active && (m_wait == 0)) check32("out_result", out_result, m_result);
    end
  end

  // Wait (bounded) for idle, present a request for one edge, then scramble inputs.
  task automatic send(input logic op, input logic [31:0] v, input logic [4:0] s);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) check1("send_timeout", 1'b0, 1'b1);
    in_valid   = 1'b1;
    in_op      = op;
    in_operand = v;
    in_shamt   = s;
    @(posedge clock);
    @(negedge clock);
    in_valid   = 1'b0;
    in_op      = 1'($urandom);
    in_operand = $urandom;
    in_shamt   = 5'($urandom);
  endtask

  // Count edges after the acceptance edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic directed(input string name, input logic op, input logic [31:0] v,
                          input logic [4:0] s, input logic [31:0] exp, input int exp_lat);
    int lat;
    send(op, v, s);
    wait_result(lat);
    check32({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check32({name, "_result"}, out_result, exp);
    check32({name, "_refmodel"}, ref_shift(op, v, s), exp);
    if (out_ready) begin
      @(negedge clock);
      check1({name, "_idle_after"}, in_ready, 1'b1);
    end
  endtask

  initial begin
    int lat;
    reset        = 1'b0;
    in_valid     = 1'b0;
    in_op        = 1'b0;
    in_operand   = 32'h0;
    in_shamt     = 5'd0;
    out_ready    = 1'b1;
    z_in_valid   = 1'b0;
    z_in_op      = 1'b0;
    z_in_operand = 32'h0;
    z_in_shamt   = 5'd0;
    z_out_ready  = 1'b1;
    n_accept     = 0;
    n_deliver    = 0;

    // Reset state, with a request already pending on the inputs.
    in_valid = 1'b1;
    in_operand = 32'hDEADBEEF;
    in_shamt = 5'd3;
    repeat (2) @(negedge clock);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check32("rst_out_result", out_result, 32'h0);
    check1("rst_slow_out_valid", z_out_valid, 1'b0);
    in_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);

    directed("sra_8000_4",  1'b1, 32'h80000000, 5'd4,  32'hF8000000, 5);
    directed("sll_1_31",    1'b0, 32'h00000001, 5'd31, 32'h80000000, 5);
    directed("sra_7fff_31", 1'b1, 32'h7FFFFFFF, 5'd31, 32'h00000000, 5);
    directed("sra_8001_31", 1'b1, 32'h80000001, 5'd31, 32'hFFFFFFFF, 5);
    directed("sra_f0f0_13", 1'b1, 32'hF0F0A5A5, 5'd13, 32'hFFFF8785, 5);
    directed("fast_zero",   1'b0, 32'h12345678, 5'd0,  32'h12345678, 0);

    // Zero amount without the bypass takes the full stage sequence.
    z_in_valid = 1'b1;
    z_in_op = 1'b0;
    z_in_operand = 32'h12345678;
    z_in_shamt = 5'd0;
    @(posedge clock);
    @(negedge clock);
    z_in_valid = 1'b0;
    z_in_operand = 32'hFFFFFFFF;
    z_in_shamt = 5'd7;
    lat = 0;
    while (!z_out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check32("slow_zero_latency", 32'(lat), 32'd5);
    check32("slow_zero_result", z_out_result, 32'h12345678);
    @(negedge clock);
    check1("slow_zero_idle_after", z_in_ready, 1'b1);

    // Backpressure: result held while the consumer stalls.
    out_ready = 1'b0;
    directed("bp_sll_f_4", 1'b0, 32'h0000000F, 5'd4, 32'h000000F0, 5);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      @(negedge clock);
      check1("bp_hold_valid", out_valid, 1'b1);
      check32("bp_hold_result", out_result, 32'h000000F0);
      check1("bp_hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check1("bp_release_idle", in_ready, 1'b1);
    check1("bp_release_valid", out_valid, 1'b0);

    // Reset asserted mid-operation aborts the request immediately.
    send(1'b1, 32'hF0000000, 5'd8);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check1("midrst_out_valid", out_valid, 1'b0);
    check32("midrst_out_result", out_result, 32'h0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    directed("after_rst_sll_1_1", 1'b0, 32'h00000001, 5'd1, 32'h00000002, 5);

    // Random regression with random consumer stalls and input churn.
    n_accept = 0;
    n_deliver = 0;
    for (int c = 0; c < 20000; c++) begin
      in_valid   = ($urandom_range(3) != 0);
      in_op      = 1'($urandom);
      in_operand = $urandom;
      in_shamt   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      out_ready  = 1'($urandom);
      @(negedge clock);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clock);
    check32("rand_accept_vs_deliver", 32'(n_deliver), 32'(n_accept));
    check1("rand_enough_traffic", (n_accept > 500), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
